// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - prefetching instruction buffer between instruction memory and decoder
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   redirect, redirect_pc   flush buffer and restart fetching at redirect_pc
//   mem_req, mem_addr       read request and byte address to instruction memory
//   mem_ready               memory accepts the current request
//   mem_rvalid, mem_rdata   in-order read response
//   inst_valid, inst_data,
//   inst_pc                 head instruction presented to the decoder
//   inst_ready              decoder accepts the head instruction
module instr_fetch_buffer #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [7:0]  inst_pc,
    input  logic        inst_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    // Repeated redirects can stack stale requests beyond one buffer's worth.
    localparam int DW = AW + 2;

    // Entries between head and fill_ptr are filled; between fill_ptr and tail
    // they are reserved (request accepted, response pending). The extra MSB on
    // each pointer distinguishes full from empty.
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] fill_ptr;
    logic [7:0]    fetch_pc;
    logic [DW-1:0] drop_cnt;

    logic [7:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [PW-1:0] count;
    logic [PW-1:0] reserved;
    logic [DW-1:0] stale_sum;
    logic          accept;
    logic          fill;
    logic          pop;

    assign count     = tail - head;
    assign reserved  = tail - fill_ptr;
    assign stale_sum = drop_cnt + DW'(reserved);

    // Gated by rst_n so the request is low for the whole reset interval.
    assign mem_req  = rst_n && !redirect && (count < PW'(DEPTH));
    assign mem_addr = fetch_pc;

    assign inst_valid = (fill_ptr != head);
    assign inst_data  = data_mem[head[AW-1:0]];
    assign inst_pc    = addr_mem[head[AW-1:0]];

    assign accept = mem_req && mem_ready;
    assign pop    = inst_valid && inst_ready;
    // Responses only land in the buffer once every stale response is drained,
    // and unsolicited responses (nothing reserved) are ignored.
    assign fill   = mem_rvalid && !redirect && (drop_cnt == '0) && (reserved != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect) begin
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            fetch_pc <= redirect_pc;
            // Every reserved entry plus any already-stale request becomes a
            // response to discard; a response arriving now retires one of them.
            drop_cnt <= stale_sum - DW'(mem_rvalid && (stale_sum != '0));
        end else begin
            if (accept) begin
                tail     <= tail + 1'b1;
                fetch_pc <= fetch_pc + 8'd4;
            end
            if (fill) begin
                fill_ptr <= fill_ptr + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (mem_rvalid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // Payload storage needs no reset: validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_mem[tail[AW-1:0]] <= fetch_pc;
        end
        if (fill) begin
            data_mem[fill_ptr[AW-1:0]] <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb/tb_instr_fetch_buffer.sv - self-checking bench for instr_fetch_buffer
module tb_instr_fetch_buffer;
    localparam int         DEPTH    = 4;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [7:0]  inst_pc;
    logic        inst_ready;

    instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        int         due;
        int         epoch;
    } pend_t;

    typedef struct {
        logic [7:0] rpc;
        int         lat;
        int         ready_pct;
        int         mready_pct;
        int         n_pop;
        logic [7:0] exp_last_pc;
    } row_t;

    pend_t      pend[$];
    logic [7:0] exp_q[$];
    logic [7:0] model_pc;
    logic [7:0] last_pc;
    logic [7:0] last_acc;
    int         filled;
    int         epoch;
    int         cyc;
    int         lat;
    int         ready_pct;
    int         mready_pct;
    int         pops;
    int         n_acc;
    int         steps;
    bit         stray;
    int         tests;
    int         fails;
    row_t       rows[5];

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {a, a ^ 8'h3C, ~a, 8'hA5};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive memory/decoder inputs, check outputs, advance the model.
    task automatic step();
        bit resp_cur;
        bit exp_req;
        resp_cur   = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(pend[0].addr);
            resp_cur   = (pend[0].epoch == epoch);
            void'(pend.pop_front());
        end else if (stray) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
        end
        inst_ready = ($urandom_range(0, 99) < ready_pct);
        mem_ready  = ($urandom_range(0, 99) < mready_pct);
        #1;
        exp_req = (exp_q.size() < DEPTH) && !redirect;
        chk("inst_valid", inst_valid, filled > 0);
        chk("mem_req", mem_req, exp_req);
        if (exp_req) chk("mem_addr", mem_addr, model_pc);
        if (filled > 0 && inst_ready) begin
            chk("inst_pc", inst_pc, exp_q[0]);
            chk("inst_data", inst_data, mem_word(exp_q[0]));
            last_pc = exp_q[0];
            void'(exp_q.pop_front());
            filled--;
            pops++;
        end
        if (mem_rvalid && resp_cur) filled++;
        if (exp_req && mem_ready) begin
            pend_t p;
            p.addr  = model_pc;
            p.due   = cyc + lat;
            p.epoch = epoch;
            pend.push_back(p);
            exp_q.push_back(model_pc);
            last_acc = model_pc;
            model_pc = model_pc + 8'd4;
            n_acc++;
        end
        if (redirect) begin
            exp_q.delete();
            filled   = 0;
            model_pc = redirect_pc;
            epoch++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_redirect(input logic [7:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        pend.delete();
        filled   = 0;
        model_pc = RESET_PC;
        epoch++;
        rst_n = 1'b1;
    endtask

    task automatic run_pops(input int n, input int budget);
        pops  = 0;
        steps = 0;
        while (pops < n && steps < budget) begin
            step();
            steps++;
        end
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; epoch = 0; filled = 0; n_acc = 0; pops = 0;
        model_pc = RESET_PC; last_pc = 8'h0; last_acc = 8'h0; stray = 1'b0;
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 8'h0; mem_ready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0; inst_ready = 1'b0;
        lat = 1; ready_pct = 100; mready_pct = 100;

        rows[0] = '{8'h00, 1, 100, 100, 8,  8'h1C};
        rows[1] = '{8'hF8, 1, 100, 100, 4,  8'h04};
        rows[2] = '{8'h40, 3, 50,  70,  10, 8'h64};
        rows[3] = '{8'h80, 2, 30,  100, 6,  8'h94};
        rows[4] = '{8'hF0, 4, 80,  50,  8,  8'h0C};

        @(negedge clk);
        do_reset();

        // Streaming: 8 instructions in 10 cycles from reset release.
        run_pops(8, 50);
        chk("stream_cycles", steps, 10);
        chk("stream_last_pc", last_pc, 8'h1C);

        // Backpressure: exactly DEPTH requests, then one pop frees a slot for 0x10.
        do_reset();
        ready_pct = 0; lat = 1; n_acc = 0;
        repeat (8) step();
        chk("bp_requests", n_acc, 4);
        chk("bp_last_addr", last_acc, 8'h0C);
        ready_pct = 100;
        step();
        ready_pct = 0;
        step();
        chk("bp_refill_count", n_acc, 5);
        chk("bp_refill_addr", last_acc, 8'h10);

        // Flush: 3 outstanding, redirect with no response that cycle.
        ready_pct = 100; lat = 5;
        do_redirect(8'h20);
        repeat (3) step();
        chk("flush_outstanding", pend.size(), 3);
        lat = 1;
        do_redirect(8'h40);
        run_pops(1, 60);
        chk("flush_first_pc", last_pc, 8'h40);

        // Redirect with a response, a pop and a full buffer in the same cycle.
        ready_pct = 0; lat = 2;
        do_redirect(8'h60);
        steps = 0;
        while (!(exp_q.size() == DEPTH && filled >= 1 && pend.size() > 0 && pend[0].due <= cyc)
               && steps < 40) begin
            step();
            steps++;
        end
        chk("edge_setup_reached", steps < 40, 1'b1);
        ready_pct = 100;
        do_redirect(8'h40);
        #1;
        chk("edge_inst_valid", inst_valid, 1'b0);
        chk("edge_mem_req", mem_req, 1'b1);
        chk("edge_mem_addr", mem_addr, 8'h40);
        lat = 1;
        run_pops(2, 60);
        chk("edge_pops", pops, 2);
        chk("edge_second_pc", last_pc, 8'h44);

        // Reset with 2 requests in flight, then stray responses before any accept.
        lat = 5;
        do_redirect(8'h80);
        repeat (2) step();
        do_reset();
        mready_pct = 0; stray = 1'b1;
        repeat (3) step();
        stray = 1'b0; mready_pct = 100; ready_pct = 100; lat = 1;
        run_pops(1, 60);
        chk("rst_restart_pc", last_pc, RESET_PC);

        for (int i = 0; i < 5; i++) begin
            lat        = rows[i].lat;
            ready_pct  = rows[i].ready_pct;
            mready_pct = rows[i].mready_pct;
            do_redirect(rows[i].rpc);
            run_pops(rows[i].n_pop, 500);
            chk("row_pops", pops, rows[i].n_pop);
            chk("row_last_pc", last_pc, rows[i].exp_last_pc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
